// File: rtl/control_unit.sv
// control_unit: multicycle control FSM for the MIPS-subset datapath.
// Outputs are decoded from the state register. Write-back selects use the
// IR opcode/funct, which stays stable for the whole instruction.
// Optional feature macro: CONTROL_UNIT_OVF_EXC_EN enables the arithmetic
// overflow exception for add/sub/addi.
// Mux select encodings (datapath input index):
//   ALUSrcA: 0=PC 1=A        ALUSrcB: 0=B 1=4 2=sext(imm) 3=sext(imm)<<2
//   IorD:    0=PC 1=ALUOut 2=exception vector
//   PCSource:0=ALU 1=ALUOut 2=jump concat 3=A 4=MDR byte
//   DataSrc: 0=ALUOut 1=MDR 2=HI 3=LO 4=imm<<16
//   RegDst:  0=rt 1=rd       SSControl: 0=word
//   ExcpCtrl:0=EXC_OPCODE_ADDR 1=EXC_OVF_ADDR 2=EXC_DIV0_ADDR
//   ALU_Control: 0=idle 1=add 2=sub 3=and
module control_unit #(
   parameter int unsigned EXC_OPCODE_ADDR = 253,
   parameter int unsigned EXC_OVF_ADDR    = 254,
   parameter int unsigned EXC_DIV0_ADDR   = 255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       overflow,
   input  logic       zr,
   input  logic       div_by0,
   input  logic       done,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       ABWrite,
   output logic       ALUOutControl,
   output logic       MDRWrite,
   output logic       HIWrite,
   output logic       LOWrite,
   output logic       EPCWrite,
   output logic       HDControl,
   output logic [2:0] ALU_Control,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] SSControl,
   output logic [1:0] ExcpCtrl,
   output logic [2:0] RegDst,
   output logic [2:0] IorD,
   output logic [2:0] PCSource,
   output logic [3:0] DataSrc,
   output logic [5:0] state_dbg
);

   // The datapath holds the vectors in single memory bytes.
   if (EXC_OPCODE_ADDR > 255 || EXC_OVF_ADDR > 255 || EXC_DIV0_ADDR > 255) begin : g_bad_vec
      $error("control_unit: exception vector addresses must fit in one byte");
   end

   typedef enum logic [5:0] {
      ST_RESET      = 6'd0,
      ST_FETCH      = 6'd1,
      ST_FETCH_WAIT = 6'd2,
      ST_IR         = 6'd3,
      ST_DECODE     = 6'd4,
      ST_R_EXEC     = 6'd5,
      ST_R_WB       = 6'd6,
      ST_MD_START   = 6'd7,
      ST_MD_WAIT    = 6'd8,
      ST_MD_WB      = 6'd9,
      ST_JR         = 6'd10,
      ST_I_EXEC     = 6'd11,
      ST_I_WB       = 6'd12,
      ST_BR         = 6'd13,
      ST_ADDR       = 6'd14,
      ST_MEM_RD     = 6'd15,
      ST_MEM_WAIT   = 6'd16,
      ST_MDR        = 6'd17,
      ST_LW_WB      = 6'd18,
      ST_SW         = 6'd19,
      ST_J          = 6'd20,
      ST_EXC_OPCODE = 6'd21,
`ifdef CONTROL_UNIT_OVF_EXC_EN
      ST_EXC_OVF    = 6'd22,
`endif
      ST_EXC_DIV0   = 6'd23,
      ST_EXC_WAIT   = 6'd24,
      ST_EXC_MDR    = 6'd25,
      ST_EXC_PC     = 6'd26
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_MFHI = 6'h10;
   localparam logic [5:0] FN_MFLO = 6'h12;
   localparam logic [5:0] FN_MULT = 6'h18;
   localparam logic [5:0] FN_DIV  = 6'h1A;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;

   localparam logic [2:0] ALU_ADD = 3'd1;
   localparam logic [2:0] ALU_SUB = 3'd2;
   localparam logic [2:0] ALU_AND = 3'd3;

   state_t state_q, state_d;
   logic   hold_q, hold_d;

`ifndef CONTROL_UNIT_OVF_EXC_EN
   logic ovf_unused;
   assign ovf_unused = overflow;
`endif

   // State register; hold_q keeps ST_RESET for one cycle after release.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_RESET;
         hold_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state: fetch sequence, opcode/funct dispatch, terminal returns.
   always_comb begin
      state_d = state_q;
      hold_d  = 1'b0;
      case (state_q)
         ST_RESET:      if (!hold_q) state_d = ST_FETCH;
         ST_FETCH:      state_d = ST_FETCH_WAIT;
         ST_FETCH_WAIT: state_d = ST_IR;
         ST_IR:         state_d = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_R: begin
                  case (funct)
                     FN_ADD, FN_SUB, FN_AND: state_d = ST_R_EXEC;
                     FN_MULT, FN_DIV:        state_d = ST_MD_START;
                     FN_MFHI, FN_MFLO:       state_d = ST_R_WB;
                     FN_JR:                  state_d = ST_JR;
                     default:                state_d = ST_EXC_OPCODE;
                  endcase
               end
               OP_ADDI:        state_d = ST_I_EXEC;
               OP_BEQ, OP_BNE: state_d = ST_BR;
               OP_LW, OP_SW:   state_d = ST_ADDR;
               OP_LUI:         state_d = ST_I_WB;
               OP_J:           state_d = ST_J;
               default:        state_d = ST_EXC_OPCODE;
            endcase
         end
`ifdef CONTROL_UNIT_OVF_EXC_EN
         ST_R_EXEC:     state_d = (overflow && funct != FN_AND) ? ST_EXC_OVF : ST_R_WB;
         ST_I_EXEC:     state_d = overflow ? ST_EXC_OVF : ST_I_WB;
         ST_EXC_OVF:    state_d = ST_EXC_WAIT;
`else
         ST_R_EXEC:     state_d = ST_R_WB;
         ST_I_EXEC:     state_d = ST_I_WB;
`endif
         ST_MD_START:   state_d = ST_MD_WAIT;
         ST_MD_WAIT:    if (done) state_d = div_by0 ? ST_EXC_DIV0 : ST_MD_WB;
         ST_ADDR:       state_d = ST_MEM_RD;
         ST_MEM_RD:     state_d = ST_MEM_WAIT;
         ST_MEM_WAIT:   state_d = (opcode == OP_SW) ? ST_SW : ST_MDR;
         ST_MDR:        state_d = ST_LW_WB;
         ST_EXC_OPCODE,
         ST_EXC_DIV0:   state_d = ST_EXC_WAIT;
         ST_EXC_WAIT:   state_d = ST_EXC_MDR;
         ST_EXC_MDR:    state_d = ST_EXC_PC;
         ST_R_WB, ST_I_WB, ST_MD_WB, ST_JR, ST_J, ST_BR,
         ST_LW_WB, ST_SW, ST_EXC_PC:
                        state_d = ST_FETCH;
         default:       state_d = ST_RESET;
      endcase
   end

   // Output decode: everything defaults to 0 (also the reset values).
   always_comb begin
      PCWrite       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      ABWrite       = 1'b0;
      ALUOutControl = 1'b0;
      MDRWrite      = 1'b0;
      HIWrite       = 1'b0;
      LOWrite       = 1'b0;
      EPCWrite      = 1'b0;
      HDControl     = 1'b0;
      ALU_Control   = 3'd0;
      ALUSrcA       = 2'd0;
      ALUSrcB       = 2'd0;
      SSControl     = 2'd0;
      ExcpCtrl      = 2'd0;
      RegDst        = 3'd0;
      IorD          = 3'd0;
      PCSource      = 3'd0;
      DataSrc       = 4'd0;
      case (state_q)
         ST_FETCH: begin
            IorD = 3'd0; ALUSrcA = 2'd0; ALUSrcB = 2'd1; ALU_Control = ALU_ADD;
         end
         ST_IR: begin
            // PC+4 is recomputed here so it can be written without ALUOut.
            IRWrite = 1'b1; PCWrite = 1'b1; PCSource = 3'd0;
            ALUSrcA = 2'd0; ALUSrcB = 2'd1; ALU_Control = ALU_ADD;
         end
         ST_DECODE: begin
            ABWrite = 1'b1; ALUOutControl = 1'b1;
            ALUSrcA = 2'd0; ALUSrcB = 2'd3; ALU_Control = ALU_ADD;
         end
         ST_R_EXEC: begin
            ALUOutControl = 1'b1; ALUSrcA = 2'd1; ALUSrcB = 2'd0;
            case (funct)
               FN_SUB:  ALU_Control = ALU_SUB;
               FN_AND:  ALU_Control = ALU_AND;
               default: ALU_Control = ALU_ADD;
            endcase
         end
         ST_R_WB: begin
            RegWrite = 1'b1; RegDst = 3'd1;
            case (funct)
               FN_MFHI: DataSrc = 4'd2;
               FN_MFLO: DataSrc = 4'd3;
               default: DataSrc = 4'd0;
            endcase
         end
         ST_MD_START: HDControl = 1'b1;
         ST_MD_WB: begin
            HIWrite = 1'b1; LOWrite = 1'b1;
         end
         ST_JR: begin
            PCWrite = 1'b1; PCSource = 3'd3;
         end
         ST_I_EXEC, ST_ADDR: begin
            ALUOutControl = 1'b1; ALUSrcA = 2'd1; ALUSrcB = 2'd2; ALU_Control = ALU_ADD;
         end
         ST_I_WB: begin
            RegWrite = 1'b1; RegDst = 3'd0;
            DataSrc  = (opcode == OP_LUI) ? 4'd4 : 4'd0;
         end
         ST_BR: begin
            ALUSrcA = 2'd1; ALUSrcB = 2'd0; ALU_Control = ALU_SUB; PCSource = 3'd1;
            PCWrite = (opcode == OP_BEQ) ? zr : ~zr;
         end
         ST_MEM_RD:   IorD = 3'd1;
         ST_MDR:      MDRWrite = 1'b1;
         ST_LW_WB: begin
            RegWrite = 1'b1; RegDst = 3'd0; DataSrc = 4'd1;
         end
         ST_SW: begin
            MemWrite = 1'b1; IorD = 3'd1; SSControl = 2'd0;
         end
         ST_J: begin
            PCWrite = 1'b1; PCSource = 3'd2;
         end
         ST_EXC_OPCODE: begin
            EPCWrite = 1'b1; ALUSrcA = 2'd0; ALUSrcB = 2'd1; ALU_Control = ALU_SUB;
            IorD = 3'd2; ExcpCtrl = 2'd0;
         end
`ifdef CONTROL_UNIT_OVF_EXC_EN
         ST_EXC_OVF: begin
            EPCWrite = 1'b1; ALUSrcA = 2'd0; ALUSrcB = 2'd1; ALU_Control = ALU_SUB;
            IorD = 3'd2; ExcpCtrl = 2'd1;
         end
`endif
         ST_EXC_DIV0: begin
            EPCWrite = 1'b1; ALUSrcA = 2'd0; ALUSrcB = 2'd1; ALU_Control = ALU_SUB;
            IorD = 3'd2; ExcpCtrl = 2'd2;
         end
         ST_EXC_MDR:  MDRWrite = 1'b1;
         ST_EXC_PC: begin
            PCWrite = 1'b1; PCSource = 3'd4;
         end
         default: ;
      endcase
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction stream against a cycle-schedule
// model (which enable fires in which cycle of each instruction), plus
// directed cases with hand-computed cycle numbers.
module tb_control_unit;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = '0, funct = '0;
   logic       overflow = 1'b0, zr = 1'b0, div_by0 = 1'b0, done = 1'b0;
   logic       PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutControl;
   logic       MDRWrite, HIWrite, LOWrite, EPCWrite, HDControl;
   logic [2:0] ALU_Control, RegDst, IorD, PCSource;
   logic [1:0] ALUSrcA, ALUSrcB, SSControl, ExcpCtrl;
   logic [3:0] DataSrc;
   logic [5:0] state_dbg;

   control_unit dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
      .overflow(overflow), .zr(zr), .div_by0(div_by0), .done(done),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .ABWrite(ABWrite), .ALUOutControl(ALUOutControl), .MDRWrite(MDRWrite),
      .HIWrite(HIWrite), .LOWrite(LOWrite), .EPCWrite(EPCWrite), .HDControl(HDControl),
      .ALU_Control(ALU_Control), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .SSControl(SSControl), .ExcpCtrl(ExcpCtrl), .RegDst(RegDst), .IorD(IorD),
      .PCSource(PCSource), .DataSrc(DataSrc), .state_dbg(state_dbg)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [2:0] alu; logic [1:0] asa; logic [1:0] asb; logic [1:0] ss; logic [1:0] xc;
      logic [2:0] rd;  logic [2:0] iod; logic [2:0] pcs; logic [3:0] ds;
   } sel_t;

   // enable bit positions in the packed enable vector
   localparam int PCW = 10, MEMW = 9, IRW = 8, REGW = 7, ABW = 6, AOC = 5;
   localparam int MDRW = 4, HIW = 3, LOW = 2, EPCW = 1, HDC = 0;
   // instruction classes
   localparam int C_ALU = 0, C_ADDI = 1, C_BR = 2, C_J = 3, C_JR = 4, C_LUI = 5;
   localparam int C_MFHI = 6, C_MFLO = 7, C_LW = 8, C_SW = 9, C_MD = 10, C_BAD = 11;

   logic [10:0] act_en, exp_en;
   sel_t        act_sel, exp_sel, msk_sel;
   logic        chk_on = 1'b0, exp_fetch = 1'b0;
   int          cur_k = 0;
   int          n_chk = 0, n_fail = 0;

   assign act_en  = {PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutControl,
                     MDRWrite, HIWrite, LOWrite, EPCWrite, HDControl};
   assign act_sel = {ALU_Control, ALUSrcA, ALUSrcB, SSControl, ExcpCtrl,
                     RegDst, IorD, PCSource, DataSrc};

   // observations for the hand-computed checks
   int          rw_k, epc_k, hi_k, mw_k, hd_n;
   logic [31:0] pcw_bits;
   logic        rst_win = 1'b0, mw_glitch = 1'b0;

   always @(MemWrite) if (rst_win && MemWrite) mw_glitch = 1'b1;

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Per-cycle compare against the model expectations.
   always @(negedge clock) begin
      if (chk_on) begin
         check_val($sformatf("enables k=%0d", cur_k), {21'd0, act_en}, {21'd0, exp_en});
         check_val($sformatf("selects k=%0d", cur_k), {8'd0, act_sel & msk_sel},
                   {8'd0, exp_sel & msk_sel});
         if (exp_fetch) check_val("fetch entry state", {26'd0, state_dbg}, 32'd1);
      end
   end

   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00: case (fn)
                   6'h20, 6'h22, 6'h24: return C_ALU;
                   6'h18, 6'h1A:        return C_MD;
                   6'h10:               return C_MFHI;
                   6'h12:               return C_MFLO;
                   6'h08:               return C_JR;
                   default:             return C_BAD;
                endcase
         6'h08: return C_ADDI;
         6'h04, 6'h05: return C_BR;
         6'h02: return C_J;
         6'h0F: return C_LUI;
         6'h23: return C_LW;
         6'h2B: return C_SW;
         default: return C_BAD;
      endcase
   endfunction

   // Schedule model: what must happen in cycle k (k=1 is the fetch cycle).
   task automatic model(input int cls, input logic [5:0] op, input logic [5:0] fn,
                        input logic zr_v, input int e, input logic [1:0] xc,
                        input int len, input int k,
                        output logic [10:0] en, output sel_t s, output sel_t m);
      en = '0; s = '0; m = '0;
      if (k == 1) begin s.alu = 3'd1; s.asb = 2'd1; m.alu = '1; m.asb = '1; m.iod = '1; end
      if (k == 3) begin en[IRW] = 1; en[PCW] = 1; m.pcs = '1; end
      if (k == 4) begin en[ABW] = 1; en[AOC] = 1; s.alu = 3'd1; s.asb = 2'd3; m.alu = '1; m.asb = '1; end
      if (e != 0 && k >= e) begin
         if (k == e) begin
            en[EPCW] = 1; s.alu = 3'd2; s.asa = 2'd0; s.asb = 2'd1; s.iod = 3'd2; s.xc = xc;
            m.alu = '1; m.asa = '1; m.asb = '1; m.iod = '1; m.xc = '1;
         end
         if (k == e + 2) en[MDRW] = 1;
         if (k == e + 3) begin en[PCW] = 1; s.pcs = 3'd4; m.pcs = '1; end
      end else if (k >= 5) begin
         case (cls)
            C_ALU, C_ADDI: begin
               if (k == 5) begin
                  en[AOC] = 1; s.asa = 2'd1; m.asa = '1; m.alu = '1; m.asb = '1;
                  if (cls == C_ADDI) begin s.alu = 3'd1; s.asb = 2'd2; end
                  else s.alu = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : 3'd3;
               end
               if (k == 6) begin
                  en[REGW] = 1; s.rd = (cls == C_ALU) ? 3'd1 : 3'd0; m.rd = '1; m.ds = '1;
               end
            end
            C_BR: begin
               en[PCW] = (op == 6'h04) ? zr_v : !zr_v;
               s.alu = 3'd2; s.pcs = 3'd1; m.alu = '1; m.pcs = '1;
            end
            C_J:  begin en[PCW] = 1; s.pcs = 3'd2; m.pcs = '1; end
            C_JR: begin en[PCW] = 1; s.pcs = 3'd3; m.pcs = '1; end
            C_LUI:  begin en[REGW] = 1; s.ds = 4'd4; m.ds = '1; m.rd = '1; end
            C_MFHI: begin en[REGW] = 1; s.ds = 4'd2; s.rd = 3'd1; m.ds = '1; m.rd = '1; end
            C_MFLO: begin en[REGW] = 1; s.ds = 4'd3; s.rd = 3'd1; m.ds = '1; m.rd = '1; end
            C_LW, C_SW: begin
               if (k == 5) begin
                  en[AOC] = 1; s.alu = 3'd1; s.asa = 2'd1; s.asb = 2'd2;
                  m.alu = '1; m.asa = '1; m.asb = '1;
               end
               if (k == 6) begin s.iod = 3'd1; m.iod = '1; end
               if (cls == C_LW && k == 8) en[MDRW] = 1;
               if (cls == C_LW && k == 9) begin en[REGW] = 1; s.ds = 4'd1; m.ds = '1; m.rd = '1; end
               if (cls == C_SW && k == 8) begin en[MEMW] = 1; m.ss = '1; end
            end
            C_MD: begin
               if (k == 5) en[HDC] = 1;
               if (k == len) begin en[HIW] = 1; en[LOW] = 1; end
            end
            default: ;
         endcase
      end
   endtask

   task automatic reset_mid_instr();
      chk_on = 1'b0;
      #1 reset = 1'b1; rst_win = 1'b1;
      #1;
      check_val("reset enables immediate", {21'd0, act_en}, 32'd0);
      check_val("reset selects immediate", {8'd0, act_sel}, 32'd0);
      check_val("reset state immediate", {26'd0, state_dbg}, 32'd0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      check_val("state 1 edge after release", {26'd0, state_dbg}, 32'd0);
      @(posedge clock); #1;
      check_val("state 2 edges after release", {26'd0, state_dbg}, 32'd1);
      rst_win = 1'b0;
      check_val("no MemWrite around reset", {31'd0, mw_glitch}, 32'd0);
   endtask

   // Runs one instruction; entry and exit are 1 time unit after the edge
   // that enters ST_FETCH. d = cycle in which done pulses (mult/div only).
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zr_v,
                            input logic ovf_v, input int d, input logic dz, input int abort_k);
      int cls, e, len;
      logic [1:0] xc;
      logic [10:0] en;
      sel_t s, m;
      cls = classify(op, fn);
      e = 0; xc = 2'd0;
      len = 5;
      case (cls)
         C_ALU, C_ADDI: len = 6;
         C_LW: len = 9;
         C_SW: len = 8;
         C_MD: len = d + 1;
         default: len = 5;
      endcase
      if (cls == C_BAD) e = 5;
`ifdef CONTROL_UNIT_OVF_EXC_EN
      if (ovf_v && (cls == C_ADDI || (cls == C_ALU && fn != 6'h24))) begin e = 6; xc = 2'd1; end
`endif
      if (cls == C_MD && dz) begin e = d + 1; xc = 2'd2; end
      if (e != 0) len = e + 3;
      rw_k = 0; epc_k = 0; hi_k = 0; mw_k = 0; hd_n = 0; pcw_bits = '0;
      for (int k = 1; k <= len; k++) begin
         opcode = op; funct = fn;
         zr       = (k == 5) ? zr_v  : 1'($urandom_range(0, 1));
         overflow = (k == 5) ? ovf_v : 1'($urandom_range(0, 1));
         if (cls == C_MD) begin
            done    = (k == d) ? 1'b1 : (k <= 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            div_by0 = (k == d) ? dz : 1'($urandom_range(0, 1));
         end else begin
            done    = 1'($urandom_range(0, 1));
            div_by0 = 1'($urandom_range(0, 1));
         end
         if (k == abort_k) begin
            reset_mid_instr();
            return;
         end
         model(cls, op, fn, zr_v, e, xc, len, k, en, s, m);
         exp_en = en; exp_sel = s; msk_sel = m; exp_fetch = (k == 1); cur_k = k; chk_on = 1'b1;
         @(negedge clock);
         if (RegWrite && rw_k == 0) rw_k = k;
         if (EPCWrite && epc_k == 0) epc_k = k;
         if (HIWrite && hi_k == 0) hi_k = k;
         if (MemWrite && mw_k == 0) mw_k = k;
         if (HDControl) hd_n++;
         if (PCWrite) pcw_bits[k] = 1'b1;
         @(posedge clock); #1;
      end
   endtask

   initial begin
      logic [5:0] op, fn;
      int sel, d;
      logic dz;
      // reset state
      @(posedge clock); @(posedge clock); #1;
      check_val("reset enables", {21'd0, act_en}, 32'd0);
      check_val("reset selects", {8'd0, act_sel}, 32'd0);
      check_val("reset state", {26'd0, state_dbg}, 32'd0);
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;
      check_val("held in reset 1 cycle", {26'd0, state_dbg}, 32'd0);
      @(posedge clock); #1;

      // add: RegWrite cycle 6, PCWrite only cycle 3
      run_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, 1'b0, 0);
      check_val("add RegWrite cycle", rw_k, 32'd6);
      check_val("add PCWrite cycles", pcw_bits, 32'h8);
      // branches
      run_instr(6'h04, 6'h00, 1'b1, 1'b0, 0, 1'b0, 0);
      check_val("beq zr=1 PCWrite", pcw_bits, 32'h28);
      run_instr(6'h04, 6'h00, 1'b0, 1'b0, 0, 1'b0, 0);
      check_val("beq zr=0 PCWrite", pcw_bits, 32'h08);
      run_instr(6'h05, 6'h00, 1'b0, 1'b0, 0, 1'b0, 0);
      check_val("bne zr=0 PCWrite", pcw_bits, 32'h28);
      run_instr(6'h05, 6'h00, 1'b1, 1'b0, 0, 1'b0, 0);
      check_val("bne zr=1 PCWrite", pcw_bits, 32'h08);
      // mult, done 10 cycles after HDControl (cycle 5 -> 15)
      run_instr(6'h00, 6'h18, 1'b0, 1'b0, 15, 1'b0, 0);
      check_val("mult HDControl cycles", hd_n, 32'd1);
      check_val("mult HIWrite cycle", hi_k, 32'd16);
      // div by zero, done on entry to the wait state
      run_instr(6'h00, 6'h1A, 1'b0, 1'b0, 6, 1'b1, 0);
      check_val("div0 EPCWrite cycle", epc_k, 32'd7);
      check_val("div0 no HIWrite", hi_k, 32'd0);
      // invalid opcode
      run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 0, 1'b0, 0);
      check_val("bad op EPCWrite cycle", epc_k, 32'd5);
      check_val("bad op PCWrite cycles", pcw_bits, 32'h108);
      // addi with overflow
      run_instr(6'h08, 6'h00, 1'b0, 1'b1, 0, 1'b0, 0);
`ifdef CONTROL_UNIT_OVF_EXC_EN
      check_val("addi ovf RegWrite", rw_k, 32'd0);
      check_val("addi ovf EPCWrite cycle", epc_k, 32'd6);
`else
      check_val("addi ovf RegWrite cycle", rw_k, 32'd6);
`endif
      // sw, then sw with reset in its memory-wait cycle
      run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 0, 1'b0, 0);
      check_val("sw MemWrite cycle", mw_k, 32'd8);
      run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 0, 1'b0, 7);
      run_instr(6'h23, 6'h00, 1'b0, 1'b0, 0, 1'b0, 0);
      check_val("lw RegWrite cycle", rw_k, 32'd9);

      // random instruction stream
      for (int i = 0; i < 200; i++) begin
         sel = $urandom_range(0, 16);
         op = 6'h00; fn = 6'h00; d = 0; dz = 1'b0;
         case (sel)
            0: fn = 6'h20;  1: fn = 6'h22;  2: fn = 6'h24;
            3: fn = 6'h18;  4: fn = 6'h1A;  5: fn = 6'h10;
            6: fn = 6'h12;  7: fn = 6'h08;  8: op = 6'h08;
            9: op = 6'h04; 10: op = 6'h05; 11: op = 6'h23;
            12: op = 6'h2B; 13: op = 6'h0F; 14: op = 6'h02;
            15: begin
               op = 6'($urandom_range(0, 63));
               while (classify(op, 6'h20) != C_BAD) op = 6'($urandom_range(0, 63));
            end
            default: begin
               fn = 6'($urandom_range(0, 63));
               while (classify(6'h00, fn) != C_BAD) fn = 6'($urandom_range(0, 63));
            end
         endcase
         if (classify(op, fn) == C_MD) begin
            d = $urandom_range(6, 14);
            dz = (fn == 6'h1A) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d, dz, 0);
      end
      // final fetch entry check
      model(C_ALU, 6'h00, 6'h20, 1'b0, 0, 2'd0, 6, 1, exp_en, exp_sel, msk_sel);
      exp_fetch = 1'b1; cur_k = 1; chk_on = 1'b1;
      @(negedge clock);
      chk_on = 1'b0;
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
